// File: rtl/clk_div_cfg_ctrl.sv
// Per-domain clock-divider controller: registered enable strobe and divided phase with glitch-free divide updates.
// Optional strobe counter output ce_cnt_o is built when CLK_DIV_CTRL_CE_CNT_EN is defined.
module clk_div_cfg_ctrl #(
   parameter int DIV_WIDTH = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 p_clk,
   input  logic                 p_rst,
   input  logic [DIV_WIDTH-1:0] reg_div_i,
   input  logic                 reg_tog_i,
   input  logic                 reg_cken_i,
   input  logic                 reg_icg_on_i,
   output logic                 ce_o,
   output logic                 clk_ph_o,
   output logic [DIV_WIDTH-1:0] div_act_o,
   output logic                 upd_pend_o,
   output logic                 upd_done_o,
   output logic [1:0]           state_dbg_o
`ifdef CLK_DIV_CTRL_CE_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] ce_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
   logic [DIV_WIDTH-1:0] div_shadow_q, div_shadow_d;
   logic                 tog_q, tog_d;
   logic                 ce_q, ce_d;
   logic                 ph_q, ph_d;
   logic                 done_q, done_d;
   logic                 en;
   logic                 tog_rise;
   logic                 wrap;
   logic                 start;

   always_comb begin
      en           = reg_cken_i & reg_icg_on_i;
      tog_rise     = reg_tog_i & ~tog_q;
      wrap         = (cnt_q == div_act_q);
      state_d      = state_q;
      cnt_d        = cnt_q;
      div_act_d    = div_act_q;
      div_shadow_d = div_shadow_q;
      tog_d        = reg_tog_i;
      ce_d         = 1'b0;
      done_d       = 1'b0;
      start        = 1'b0;

      case (state_q)
         ST_OFF: begin
            cnt_d = '0;
            if (en) begin
               div_act_d = reg_div_i;
               state_d   = ST_RUN;
               start     = 1'b1;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end else begin
               ce_d  = wrap;
               cnt_d = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
               // A request landing on a wrap is shadowed and applied at the following wrap.
               if (tog_rise) begin
                  div_shadow_d = reg_div_i;
                  state_d      = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (!en) begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end else begin
               ce_d = wrap;
               if (wrap) begin
                  cnt_d     = '0;
                  div_act_d = div_shadow_q;
                  done_d    = 1'b1;
                  state_d   = tog_rise ? ST_PEND : ST_RUN;
               end else begin
                  cnt_d = cnt_q + DIV_WIDTH'(1);
               end
               if (tog_rise) div_shadow_d = reg_div_i;
            end
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end
      endcase

      ph_d = ph_q ^ ce_d;
   end

   always_ff @(posedge p_clk) begin
      if (p_rst) begin
         state_q      <= ST_OFF;
         cnt_q        <= '0;
         div_act_q    <= '0;
         div_shadow_q <= '0;
         tog_q        <= 1'b0;
         ce_q         <= 1'b0;
         ph_q         <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_act_q    <= div_act_d;
         div_shadow_q <= div_shadow_d;
         tog_q        <= tog_d;
         ce_q         <= ce_d;
         ph_q         <= ph_d;
         done_q       <= done_d;
      end
   end

   assign ce_o        = ce_q;
   assign clk_ph_o    = ph_q;
   assign div_act_o   = div_act_q;
   assign upd_pend_o  = (state_q == ST_PEND);
   assign upd_done_o  = done_q;
   assign state_dbg_o = state_q;

`ifdef CLK_DIV_CTRL_CE_CNT_EN
   logic [CNT_WIDTH-1:0] ce_cnt_q, ce_cnt_d;

   always_comb begin
      ce_cnt_d = ce_cnt_q;
      if (start) begin
         ce_cnt_d = '0;
      end else if (ce_d && (ce_cnt_q != {CNT_WIDTH{1'b1}})) begin
         ce_cnt_d = ce_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge p_clk) begin
      if (p_rst) ce_cnt_q <= '0;
      else       ce_cnt_q <= ce_cnt_d;
   end

   assign ce_cnt_o = ce_cnt_q;
`else
   logic unused_start;
   assign unused_start = start;
`endif

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: enable latency, shadowed updates, disable and reset paths.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_clk_div_cfg_ctrl;

   localparam int DW = 4;
   localparam int CW = 16;
   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_PEND = 2'd2;

   logic          p_clk = 1'b0;
   logic          p_rst;
   logic [DW-1:0] reg_div_i;
   logic          reg_tog_i;
   logic          reg_cken_i;
   logic          reg_icg_on_i;
   logic          ce_o;
   logic          clk_ph_o;
   logic [DW-1:0] div_act_o;
   logic          upd_pend_o;
   logic          upd_done_o;
   logic [1:0]    state_dbg_o;
`ifdef CLK_DIV_CTRL_CE_CNT_EN
   logic [CW-1:0] ce_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   clk_div_cfg_ctrl #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .p_clk        (p_clk),
      .p_rst        (p_rst),
      .reg_div_i    (reg_div_i),
      .reg_tog_i    (reg_tog_i),
      .reg_cken_i   (reg_cken_i),
      .reg_icg_on_i (reg_icg_on_i),
      .ce_o         (ce_o),
      .clk_ph_o     (clk_ph_o),
      .div_act_o    (div_act_o),
      .upd_pend_o   (upd_pend_o),
      .upd_done_o   (upd_done_o),
      .state_dbg_o  (state_dbg_o)
`ifdef CLK_DIV_CTRL_CE_CNT_EN
      ,
      .ce_cnt_o     (ce_cnt_o)
`endif
   );

   always #5 p_clk = ~p_clk;

   task automatic tick();
      @(posedge p_clk);
      #1;
   endtask

   task automatic test_reset();
      p_rst = 1'b1; reg_div_i = '0; reg_tog_i = 1'b0;
      reg_cken_i = 1'b0; reg_icg_on_i = 1'b0;
      tick(); tick();
      p_rst = 1'b0;
      checks++;
      if ({ce_o, clk_ph_o, upd_pend_o, upd_done_o} !== 4'b0000 || div_act_o !== 4'd0 || state_dbg_o !== S_OFF) begin
         errors++;
         $display("FAIL reset: ce=%b ph=%b pend=%b done=%b div_act=%0d state=%0d, required all 0",
                  ce_o, clk_ph_o, upd_pend_o, upd_done_o, div_act_o, state_dbg_o);
      end
      tick();
      checks++;
      if (ce_o !== 1'b0 || state_dbg_o !== S_OFF) begin
         errors++;
         $display("FAIL off_idle: ce=%b state=%0d, required ce=0 state=OFF", ce_o, state_dbg_o);
      end
   endtask

   // div=3: strobe every 4th edge after the enable edge; phase flips on each strobe.
   task automatic test_basic();
      logic ph_exp;
      reg_div_i = 4'd3; reg_cken_i = 1'b1; reg_icg_on_i = 1'b1;
      tick();
      checks++;
      if (state_dbg_o !== S_RUN || div_act_o !== 4'd3 || ce_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_start: state=%0d div_act=%0d ce=%b, required RUN 3 0", state_dbg_o, div_act_o, ce_o);
      end
      ph_exp = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i % 4 == 0) ph_exp = ~ph_exp;
         checks++;
         if (ce_o !== (i % 4 == 0) || clk_ph_o !== ph_exp) begin
            errors++;
            $display("FAIL basic_ce t=%0d: ce=%b ph=%b, required ce=%b ph=%b", i, ce_o, clk_ph_o, (i % 4 == 0), ph_exp);
         end
      end
`ifdef CLK_DIV_CTRL_CE_CNT_EN
      checks++;
      if (ce_cnt_o !== 16'd3) begin
         errors++;
         $display("FAIL basic_cnt: ce_cnt=%0d, required 3", ce_cnt_o);
      end
`endif
   endtask

   // Running div=3 at cnt=0; change to div=1 mid-period.
   task automatic test_update();
      int done_cnt;
      tick();
      reg_div_i = 4'd1; reg_tog_i = 1'b1;
      tick();
      reg_tog_i = 1'b0;
      checks++;
      if (upd_pend_o !== 1'b1 || div_act_o !== 4'd3) begin
         errors++;
         $display("FAIL upd_pend: pend=%b div_act=%0d, required 1 3", upd_pend_o, div_act_o);
      end
      tick();
      checks++;
      if (upd_pend_o !== 1'b1 || ce_o !== 1'b0) begin
         errors++;
         $display("FAIL upd_hold: pend=%b ce=%b, required 1 0", upd_pend_o, ce_o);
      end
      tick();
      checks++;
      if (ce_o !== 1'b1 || upd_done_o !== 1'b1 || upd_pend_o !== 1'b0 || div_act_o !== 4'd1) begin
         errors++;
         $display("FAIL upd_apply: ce=%b done=%b pend=%b div_act=%0d, required 1 1 0 1",
                  ce_o, upd_done_o, upd_pend_o, div_act_o);
      end
      done_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (upd_done_o === 1'b1) done_cnt++;
         checks++;
         if (ce_o !== (i % 2 == 0)) begin
            errors++;
            $display("FAIL upd_spacing t=%0d: ce=%b, required %b", i, ce_o, (i % 2 == 0));
         end
      end
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL upd_done_once: extra done pulses=%0d, required 0", done_cnt);
      end
   endtask

   // Running div=1 at cnt=0: restore div=3, then request 3->0 exactly on a wrap.
   task automatic test_wrap_tog();
      reg_div_i = 4'd3; reg_tog_i = 1'b1;
      tick();
      reg_tog_i = 1'b0;
      tick();
      checks++;
      if (div_act_o !== 4'd3 || upd_done_o !== 1'b1 || ce_o !== 1'b1) begin
         errors++;
         $display("FAIL wrap_setup: div_act=%0d done=%b ce=%b, required 3 1 1", div_act_o, upd_done_o, ce_o);
      end
      tick(); tick(); tick();
      reg_div_i = 4'd0; reg_tog_i = 1'b1;
      tick();
      reg_tog_i = 1'b0;
      checks++;
      if (ce_o !== 1'b1 || upd_pend_o !== 1'b1 || div_act_o !== 4'd3 || upd_done_o !== 1'b0) begin
         errors++;
         $display("FAIL wrap_capture: ce=%b pend=%b div_act=%0d done=%b, required 1 1 3 0",
                  ce_o, upd_pend_o, div_act_o, upd_done_o);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (ce_o !== (i == 4) || upd_done_o !== (i == 4)) begin
            errors++;
            $display("FAIL wrap_period t=%0d: ce=%b done=%b, required %b %b", i, ce_o, upd_done_o, (i == 4), (i == 4));
         end
      end
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (ce_o !== 1'b1 || upd_done_o !== 1'b0 || div_act_o !== 4'd0) begin
            errors++;
            $display("FAIL wrap_div0 t=%0d: ce=%b done=%b div_act=%0d, required 1 0 0", i, ce_o, upd_done_o, div_act_o);
         end
      end
   endtask

   // Running div=0: move to div=7, then request 5 and 2 inside one period.
   task automatic test_double_tog();
      int done_cnt;
      reg_div_i = 4'd7; reg_tog_i = 1'b1;
      tick();
      reg_tog_i = 1'b0;
      tick();
      checks++;
      if (div_act_o !== 4'd7 || upd_done_o !== 1'b1) begin
         errors++;
         $display("FAIL dbl_setup: div_act=%0d done=%b, required 7 1", div_act_o, upd_done_o);
      end
      tick();
      done_cnt = 0;
      reg_div_i = 4'd5; reg_tog_i = 1'b1;
      tick(); if (upd_done_o === 1'b1) done_cnt++;
      reg_tog_i = 1'b0;
      tick(); if (upd_done_o === 1'b1) done_cnt++;
      reg_div_i = 4'd2; reg_tog_i = 1'b1;
      tick(); if (upd_done_o === 1'b1) done_cnt++;
      reg_tog_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick(); if (upd_done_o === 1'b1) done_cnt++;
         checks++;
         if (upd_pend_o !== 1'b1 || ce_o !== 1'b0 || div_act_o !== 4'd7) begin
            errors++;
            $display("FAIL dbl_pend t=%0d: pend=%b ce=%b div_act=%0d, required 1 0 7", i, upd_pend_o, ce_o, div_act_o);
         end
      end
      tick(); if (upd_done_o === 1'b1) done_cnt++;
      checks++;
      if (ce_o !== 1'b1 || div_act_o !== 4'd2 || upd_pend_o !== 1'b0) begin
         errors++;
         $display("FAIL dbl_apply: ce=%b div_act=%0d pend=%b, required 1 2 0", ce_o, div_act_o, upd_pend_o);
      end
      for (int i = 1; i <= 3; i++) begin
         tick(); if (upd_done_o === 1'b1) done_cnt++;
         checks++;
         if (ce_o !== (i == 3)) begin
            errors++;
            $display("FAIL dbl_period t=%0d: ce=%b, required %b", i, ce_o, (i == 3));
         end
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL dbl_done_count: pulses=%0d, required 1", done_cnt);
      end
   endtask

   // Running div=2 at cnt=0: arm an update, then drop icg_on.
   task automatic test_icg_drop();
      reg_div_i = 4'd6; reg_tog_i = 1'b1;
      tick();
      reg_tog_i = 1'b0;
      checks++;
      if (upd_pend_o !== 1'b1) begin
         errors++;
         $display("FAIL icg_arm: pend=%b, required 1", upd_pend_o);
      end
      reg_icg_on_i = 1'b0;
      tick();
      checks++;
      if (state_dbg_o !== S_OFF || ce_o !== 1'b0 || upd_pend_o !== 1'b0 || div_act_o !== 4'd2) begin
         errors++;
         $display("FAIL icg_off: state=%0d ce=%b pend=%b div_act=%0d, required OFF 0 0 2",
                  state_dbg_o, ce_o, upd_pend_o, div_act_o);
      end
      reg_div_i = 4'd2; reg_tog_i = 1'b1;
      tick();
      reg_tog_i = 1'b0;
      checks++;
      if (state_dbg_o !== S_OFF || upd_pend_o !== 1'b0 || ce_o !== 1'b0) begin
         errors++;
         $display("FAIL icg_tog_ignored: state=%0d pend=%b ce=%b, required OFF 0 0", state_dbg_o, upd_pend_o, ce_o);
      end
      reg_icg_on_i = 1'b1;
      tick();
      checks++;
      if (state_dbg_o !== S_RUN || div_act_o !== 4'd2) begin
         errors++;
         $display("FAIL icg_reenable: state=%0d div_act=%0d, required RUN 2", state_dbg_o, div_act_o);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (ce_o !== (i == 3)) begin
            errors++;
            $display("FAIL icg_first_ce t=%0d: ce=%b, required %b", i, ce_o, (i == 3));
         end
      end
   endtask

   task automatic test_reset_mid();
      reg_cken_i = 1'b0;
      tick();
      reg_div_i = 4'd0; reg_cken_i = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (ce_o !== 1'b1 || div_act_o !== 4'd0) begin
         errors++;
         $display("FAIL rst_setup: ce=%b div_act=%0d, required 1 0", ce_o, div_act_o);
      end
      p_rst = 1'b1;
      tick();
      p_rst = 1'b0;
      checks++;
      if ({ce_o, clk_ph_o, upd_pend_o, upd_done_o} !== 4'b0000 || div_act_o !== 4'd0 || state_dbg_o !== S_OFF) begin
         errors++;
         $display("FAIL rst_mid: ce=%b ph=%b pend=%b done=%b div_act=%0d state=%0d, required all 0",
                  ce_o, clk_ph_o, upd_pend_o, upd_done_o, div_act_o, state_dbg_o);
      end
`ifdef CLK_DIV_CTRL_CE_CNT_EN
      checks++;
      if (ce_cnt_o !== 16'd0) begin
         errors++;
         $display("FAIL rst_cnt: ce_cnt=%0d, required 0", ce_cnt_o);
      end
`endif
      tick();
      for (int i = 1; i <= 10; i++) tick();
      checks++;
      if (ce_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_restart: ce=%b, required 1", ce_o);
      end
`ifdef CLK_DIV_CTRL_CE_CNT_EN
      checks++;
      if (ce_cnt_o !== 16'd10) begin
         errors++;
         $display("FAIL ce_cnt_10: ce_cnt=%0d, required 10", ce_cnt_o);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_update();
      test_wrap_tog();
      test_double_tog();
      test_icg_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
